// File: rtl/sysid_read_checker_if.sv
// sysid_read_checker_if
//   Avalon-MM read-only bus between the system-ID read checker (master)
//   and the system-ID slave.
//   avm_address        word address: 0 = ID, 1 = timestamp (master -> slave)
//   avm_read           read request                        (master -> slave)
//   avm_waitrequest    slave stall                         (slave -> master)
//   avm_readdata       32-bit read data                    (slave -> master)
//   avm_readdatavalid  read data qualifier                 (slave -> master)
interface sysid_read_checker_if;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;

   modport master (
      output avm_address,
      output avm_read,
      input  avm_waitrequest,
      input  avm_readdata,
      input  avm_readdatavalid
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      output avm_waitrequest,
      output avm_readdata,
      output avm_readdatavalid
   );
endinterface

// File: rtl/sysid_read_checker.sv
// sysid_read_checker
//   Avalon-MM read master that fetches the system-ID word (address 0) and the
//   timestamp word (address 1), captures both and compares them with the
//   build-time expected values.
//   clock     system clock, rising edge
//   reset_n   asynchronous active-low reset
//   start     one-cycle request to run a check (taken only from IDLE)
//   avm       Avalon-MM master side of the bus
//   busy      check in progress (request/wait phases)
//   done      check finished; held until the next accepted start
//   id_ok     captured ID equals EXPECTED_ID
//   ts_ok     captured timestamp equals EXPECTED_TIMESTAMP
//   timeout   a read exceeded TIMEOUT_CYCLES
//   id_value  captured ID word
//   ts_value  captured timestamp word
module sysid_read_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1517950283,
   parameter int unsigned TIMEOUT_CYCLES     = 255
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        start,
   sysid_read_checker_if.master        avm,
   output logic                        busy,
   output logic                        done,
   output logic                        id_ok,
   output logic                        ts_ok,
   output logic                        timeout,
   output logic [31:0]                 id_value,
   output logic [31:0]                 ts_value
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RD0_REQ  = 3'd1;
   localparam logic [2:0] RD0_WAIT = 3'd2;
   localparam logic [2:0] RD1_REQ  = 3'd3;
   localparam logic [2:0] RD1_WAIT = 3'd4;
   localparam logic [2:0] FIN      = 3'd5;

   // Last count value of a read's budget; reaching it without completion expires the read.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [2:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        read_q, read_d;
   logic        addr_q, addr_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        timeout_q, timeout_d;
   logic [31:0] id_value_q, id_value_d;
   logic [31:0] ts_value_q, ts_value_d;

   logic in_req, in_wait, next_req, next_wait, expired;

   always_comb begin
      in_req    = (state_q == RD0_REQ) || (state_q == RD1_REQ);
      in_wait   = (state_q == RD0_WAIT) || (state_q == RD1_WAIT);
      expired   = (cnt_q == TO_LAST);

      state_d    = state_q;
      done_d     = done_q;
      id_ok_d    = id_ok_q;
      ts_ok_d    = ts_ok_q;
      timeout_d  = timeout_q;
      id_value_d = id_value_q;
      ts_value_d = ts_value_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RD0_REQ;
               done_d    = 1'b0;
               id_ok_d   = 1'b0;
               ts_ok_d   = 1'b0;
               timeout_d = 1'b0;
            end
         end
         RD0_REQ, RD1_REQ: begin
            // avm_read is always high in a REQ state, so no stall means accepted.
            if (!avm.avm_waitrequest) begin
               state_d = (state_q == RD0_REQ) ? RD0_WAIT : RD1_WAIT;
            end else if (expired) begin
               timeout_d = 1'b1;
               state_d   = FIN;
            end
         end
         RD0_WAIT: begin
            if (avm.avm_readdatavalid) begin
               id_value_d = avm.avm_readdata;
               id_ok_d    = (avm.avm_readdata == EXPECTED_ID);
               state_d    = RD1_REQ;
            end else if (expired) begin
               timeout_d = 1'b1;
               state_d   = FIN;
            end
         end
         RD1_WAIT: begin
            if (avm.avm_readdatavalid) begin
               ts_value_d = avm.avm_readdata;
               ts_ok_d    = (avm.avm_readdata == EXPECTED_TIMESTAMP);
               state_d    = FIN;
            end else if (expired) begin
               timeout_d = 1'b1;
               state_d   = FIN;
            end
         end
         FIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      next_req  = (state_d == RD0_REQ) || (state_d == RD1_REQ);
      next_wait = (state_d == RD0_WAIT) || (state_d == RD1_WAIT);

      // Budget spans the REQ and WAIT phases of one read; restarts on each REQ entry.
      cnt_d = cnt_q;
      if (next_req && (state_d != state_q)) begin
         cnt_d = 16'd0;
      end else if (in_req || in_wait) begin
         cnt_d = cnt_q + 16'd1;
      end

      // Bus and status outputs are registered from the next state.
      read_d = next_req;
      addr_d = (state_d == RD1_REQ) || (state_d == RD1_WAIT);
      busy_d = next_req || next_wait;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= 16'd0;
         read_q     <= 1'b0;
         addr_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         id_ok_q    <= 1'b0;
         ts_ok_q    <= 1'b0;
         timeout_q  <= 1'b0;
         id_value_q <= 32'd0;
         ts_value_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         read_q     <= read_d;
         addr_q     <= addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         id_ok_q    <= id_ok_d;
         ts_ok_q    <= ts_ok_d;
         timeout_q  <= timeout_d;
         id_value_q <= id_value_d;
         ts_value_q <= ts_value_d;
      end
   end

   assign avm.avm_read    = read_q;
   assign avm.avm_address = addr_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign id_ok           = id_ok_q;
   assign ts_ok           = ts_ok_q;
   assign timeout         = timeout_q;
   assign id_value        = id_value_q;
   assign ts_value        = ts_value_q;

endmodule

// File: tb/tb_sysid_read_checker.sv
module tb_sysid_read_checker;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start, start2;
   logic        busy, done, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;
   logic        busy2, done2, id_ok2, ts_ok2, timeout2;
   logic [31:0] id_value2, ts_value2;

   int checks = 0;
   int errors = 0;

   sysid_read_checker_if bus ();
   sysid_read_checker_if bus2 ();

   sysid_read_checker dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .avm      (bus.master),
      .busy     (busy),
      .done     (done),
      .id_ok    (id_ok),
      .ts_ok    (ts_ok),
      .timeout  (timeout),
      .id_value (id_value),
      .ts_value (ts_value)
   );

   sysid_read_checker #(.TIMEOUT_CYCLES(8)) dut_to (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start2),
      .avm      (bus2.master),
      .busy     (busy2),
      .done     (done2),
      .id_ok    (id_ok2),
      .ts_ok    (ts_ok2),
      .timeout  (timeout2),
      .id_value (id_value2),
      .ts_value (ts_value2)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Slave for one read on dut: n_wait stall cycles, data returned dly cycles after acceptance.
   task automatic serve(input int n_wait, input int dly, input logic addr,
                        input logic [31:0] data);
      for (int i = 0; i < n_wait; i++) begin
         bus.avm_waitrequest = 1'b1;
         tick();
         chk("stall_read", {31'd0, bus.avm_read}, 32'd1);
         chk("stall_addr", {31'd0, bus.avm_address}, {31'd0, addr});
      end
      bus.avm_waitrequest = 1'b0;
      tick();
      chk("accept_read_drop", {31'd0, bus.avm_read}, 32'd0);
      for (int i = 0; i < dly - 1; i++) tick();
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = data;
      tick();
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = 32'd0;
   endtask

   initial begin
      reset_n                = 1'b0;
      start                  = 1'b0;
      start2                 = 1'b0;
      bus.avm_waitrequest    = 1'b0;
      bus.avm_readdata       = 32'd0;
      bus.avm_readdatavalid  = 1'b0;
      bus2.avm_waitrequest   = 1'b0;
      bus2.avm_readdata      = 32'd0;
      bus2.avm_readdatavalid = 1'b0;
      repeat (2) tick();

      // Reset values
      chk("rst_read", {31'd0, bus.avm_read}, 32'd0);
      chk("rst_addr", {31'd0, bus.avm_address}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
      chk("rst_id_value", id_value, 32'd0);
      chk("rst_ts_value", ts_value, 32'd0);
      reset_n = 1'b1;
      tick();

      // Zero-wait slave, matching values: done at start+5
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_read", {31'd0, bus.avm_read}, 32'd1);
      chk("t1_addr0", {31'd0, bus.avm_address}, 32'd0);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      serve(0, 1, 1'b0, 32'd0);
      chk("t1_read1", {31'd0, bus.avm_read}, 32'd1);
      chk("t1_addr1", {31'd0, bus.avm_address}, 32'd1);
      serve(0, 1, 1'b1, 32'd1517950283);
      chk("t1_fin_done", {31'd0, done}, 32'd0);
      chk("t1_fin_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("t1_done", {31'd0, done}, 32'd1);
      chk("t1_flags", {29'd0, id_ok, ts_ok, timeout}, 32'b110);
      chk("t1_ts_value", ts_value, 32'h5A7A154B);
      chk("t1_id_value", id_value, 32'd0);

      // Wrong timestamp, start pulsed while busy and in FIN
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t2_done_clr", {31'd0, done}, 32'd0);
      chk("t2_flags_clr", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
      chk("t2_ts_hold", ts_value, 32'h5A7A154B);
      serve(0, 1, 1'b0, 32'd0);
      start = 1'b1;
      serve(0, 1, 1'b1, 32'h12345678);
      chk("t2_fin_done", {31'd0, done}, 32'd0);
      tick();
      start = 1'b0;
      chk("t2_done", {31'd0, done}, 32'd1);
      chk("t2_flags", {29'd0, id_ok, ts_ok, timeout}, 32'b100);
      chk("t2_ts_value", ts_value, 32'h12345678);
      repeat (3) tick();
      chk("t2_no_rerun_busy", {31'd0, busy}, 32'd0);
      chk("t2_no_rerun_read", {31'd0, bus.avm_read}, 32'd0);
      chk("t2_done_held", {31'd0, done}, 32'd1);

      // 3 waitrequest cycles and readdatavalid 2 cycles after acceptance: done at start+13
      start = 1'b1;
      tick();
      start = 1'b0;
      serve(3, 2, 1'b0, 32'd0);
      serve(3, 2, 1'b1, 32'd1517950283);
      chk("t3_fin_done", {31'd0, done}, 32'd0);
      tick();
      chk("t3_done", {31'd0, done}, 32'd1);
      chk("t3_flags", {29'd0, id_ok, ts_ok, timeout}, 32'b110);

      // Timeout with TIMEOUT_CYCLES=8, no readdatavalid
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      repeat (7) tick();
      chk("t4_no_timeout_yet", {31'd0, timeout2}, 32'd0);
      chk("t4_busy_yet", {31'd0, busy2}, 32'd1);
      tick();
      chk("t4_timeout", {31'd0, timeout2}, 32'd1);
      chk("t4_read_drop", {31'd0, bus2.avm_read}, 32'd0);
      chk("t4_busy_drop", {31'd0, busy2}, 32'd0);
      tick();
      chk("t4_done", {31'd0, done2}, 32'd1);
      chk("t4_flags", {29'd0, id_ok2, ts_ok2, timeout2}, 32'b001);
      repeat (3) tick();
      chk("t4_read_stays_low", {31'd0, bus2.avm_read}, 32'd0);

      // Reset during RD1_WAIT, stray readdatavalid after release
      start = 1'b1;
      tick();
      start = 1'b0;
      serve(0, 1, 1'b0, 32'd0);
      bus.avm_waitrequest = 1'b0;
      tick();
      chk("t5_in_wait_busy", {31'd0, busy}, 32'd1);
      chk("t5_in_wait_idok", {31'd0, id_ok}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      chk("t5_rst_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
      chk("t5_rst_ts_value", ts_value, 32'd0);
      chk("t5_rst_addr", {31'd0, bus.avm_address}, 32'd0);
      tick();
      reset_n               = 1'b1;
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = 32'hDEADBEEF;
      tick();
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = 32'd0;
      tick();
      chk("t5_stray_id", id_value, 32'd0);
      chk("t5_stray_ts", ts_value, 32'd0);
      chk("t5_stray_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
      chk("t5_stray_busy_done", {30'd0, busy, done}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
